// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maxnet_pkg
//  Description : Shared types and constants for the Maxnet controller slice.
//                Holds the state encoding, the popcount class and the
//                default sizing of the neuron array and iteration counter.
//  Revision    : 1.0  initial release
// ============================================================================
package maxnet_pkg;

  localparam int N_NEURONS    = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_ITER_DEF = 15;
  localparam int ITER_W_DEF   = 4;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // How many neurons are still alive
  typedef enum logic [1:0] {
    POP_ZERO = 2'd0,
    POP_ONE  = 2'd1,
    POP_MANY = 2'd2
  } pop_class_t;

endpackage
`default_nettype wire

// File: rtl/maxnet_winner_enc.sv
`default_nettype none
// ============================================================================
//  Module      : maxnet_winner_enc
//  Description : Combinational survivor classifier. Reports whether zero,
//                one or several nonzero flags are set, and the lowest set
//                index (used both for the single winner and for tie-break).
//  Revision    : 1.0  initial release
// ============================================================================
module maxnet_winner_enc
  import maxnet_pkg::*;
#(
  parameter int N  = N_NEURONS,
  parameter int IW = IDX_W
) (
  input  logic [N-1:0]  i_nonzero,
  output pop_class_t    o_class,
  output logic [IW-1:0] o_low_idx
);

  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  // Clearing the lowest set bit leaves something only if two or more bits were set
  logic [N-1:0] w_rest;
  assign w_rest = i_nonzero & (i_nonzero - c_one);

  // Classify the live-neuron count as zero / one / many
  always_comb begin
    o_class = POP_MANY;
    if (i_nonzero == '0) begin
      o_class = POP_ZERO;
    end else if (w_rest == '0) begin
      o_class = POP_ONE;
    end
  end

  // Priority encoder: scanning downward lets the lowest set index win
  always_comb begin
    o_low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_nonzero[i]) begin
        o_low_idx = IW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/maxnet_controller.sv
`default_nettype none
// ============================================================================
//  Module      : maxnet_controller
//  Description : Sequencer for the Maxnet datapath. Loads the initial
//                activations, then strobes one update per iteration until a
//                single neuron survives, all die, or the iteration cap hits.
//                Optional macro MAXNET_TIE_BREAK_EN: on timeout report the
//                lowest surviving index as a valid winner.
//  Revision    : 1.0  initial release
// ============================================================================
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int N_NEURONS = maxnet_pkg::N_NEURONS,
  parameter int MAX_ITER  = MAX_ITER_DEF,
  parameter int ITER_W    = ITER_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] nonzero,
  output logic                 ld_init,
  output logic                 ld_update,
  output logic                 busy,
  output logic                 done,
  output logic                 winner_valid,
  output logic [IDX_W-1:0]     winner_idx,
  output logic                 timeout,
  output logic [ITER_W-1:0]    iter_count
);

  localparam logic [ITER_W-1:0] c_max_iter = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] c_iter_one = ITER_W'(1);

  state_t            r_state;
  state_t            w_next;
  pop_class_t        w_class;
  logic [IDX_W-1:0]  w_low_idx;
  logic              w_ld_init;
  logic              w_ld_update;
  logic              w_busy;
  logic              w_done;
  logic              r_winner_valid;
  logic [IDX_W-1:0]  r_winner_idx;
  logic              r_timeout;
  logic [ITER_W-1:0] r_iter;

  maxnet_winner_enc #(
    .N  (N_NEURONS),
    .IW (IDX_W)
  ) u_winner_enc (
    .i_nonzero (nonzero),
    .o_class   (w_class),
    .o_low_idx (w_low_idx)
  );

  // State register; async reset drops every decoded strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next      = r_state;
    w_ld_init   = 1'b0;
    w_ld_update = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_ld_init = 1'b1;
        w_busy    = 1'b1;
        w_next    = CHECK;
      end
      CHECK: begin
        w_busy = 1'b1;
        // Termination is decided before any further update is issued,
        // so the counter can never step past the cap
        if (w_class != POP_MANY) begin
          w_next = DONE;
        end else if (r_iter == c_max_iter) begin
          w_next = DONE;
        end else begin
          w_next = UPDATE;
        end
      end
      UPDATE: begin
        w_ld_update = 1'b1;
        w_busy      = 1'b1;
        w_next      = CHECK;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Iteration counter and result registers; results held until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter         <= '0;
      r_winner_valid <= 1'b0;
      r_winner_idx   <= '0;
      r_timeout      <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_iter         <= '0;
        r_winner_valid <= 1'b0;
        r_winner_idx   <= '0;
        r_timeout      <= 1'b0;
      end
      if (r_state == UPDATE) begin
        r_iter <= r_iter + c_iter_one;
      end
      if (r_state == CHECK && w_next == DONE) begin
        case (w_class)
          POP_ONE: begin
            r_winner_valid <= 1'b1;
            r_winner_idx   <= w_low_idx;
          end
          POP_ZERO: begin
            r_winner_valid <= 1'b0;
            r_winner_idx   <= '0;
          end
          default: begin
            r_timeout <= 1'b1;
`ifdef MAXNET_TIE_BREAK_EN
            r_winner_valid <= 1'b1;
            r_winner_idx   <= w_low_idx;
`else
            r_winner_valid <= 1'b0;
            r_winner_idx   <= '0;
`endif
          end
        endcase
      end
    end
  end

  assign ld_init      = w_ld_init;
  assign ld_update    = w_ld_update;
  assign busy         = w_busy;
  assign done         = w_done;
  assign winner_valid = r_winner_valid;
  assign winner_idx   = r_winner_idx;
  assign timeout      = r_timeout;
  assign iter_count   = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maxnet_controller
//  Description : Self-checking bench for maxnet_controller. A task per
//                scenario drives start and a small datapath model of the
//                nonzero flags; expected results go into a scoreboard queue
//                and are popped when the run completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_maxnet_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] nonzero;
  logic       ld_init, ld_update, busy, done, winner_valid, timeout;
  logic [1:0] winner_idx;
  logic [3:0] iter_count;

  maxnet_controller #(
    .N_NEURONS (4),
    .MAX_ITER  (15),
    .ITER_W    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .nonzero      (nonzero),
    .ld_init      (ld_init),
    .ld_update    (ld_update),
    .busy         (busy),
    .done         (done),
    .winner_valid (winner_valid),
    .winner_idx   (winner_idx),
    .timeout      (timeout),
    .iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  // res = {winner_valid, winner_idx, timeout, iter_count} at done
  typedef struct {
    logic [7:0] res;
    int         lat;
    int         nupd;
    int         init_cyc;
  } res_t;

  res_t exp_q[$];
  int   exp_done_q[$];
  res_t obs;
  bit   obs_ok;
  bit   both_hi;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic res_t mk(input logic v, input logic [1:0] idx, input logic t,
                              input logic [3:0] it, input int lat, input int nupd);
    res_t r;
    r.res = {v, idx, t, it};
    r.lat = lat;
    r.nupd = nupd;
    r.init_cyc = 1;
    return r;
  endfunction

  // One run: mode 0 = single start pulse, 1 = start re-asserted while busy.
  // nonzero follows seq[k] after the k-th ld_update, like the real datapath.
  task automatic drive_run(input logic [3:0] seq[4], input res_t e, input int mode);
    int cyc;
    int nupd;
    exp_q.push_back(e);
    obs.res = 8'hff; obs.lat = -1; obs.nupd = -1; obs.init_cyc = -1;
    obs_ok = 0; both_hi = 0; nupd = 0; cyc = 0;
    nonzero = seq[0];
    start = 1'b1;
    while (cyc < 60 && !obs_ok) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 0) start = 1'b0;
      else start = busy;
      if (ld_init && ld_update) both_hi = 1;
      if (ld_init && obs.init_cyc < 0) obs.init_cyc = cyc;
      if (ld_update) begin
        nupd++;
        nonzero = seq[(nupd > 3) ? 3 : nupd];
      end
      if (done) begin
        obs_ok = 1;
        obs.res = {winner_valid, winner_idx, timeout, iter_count};
        obs.lat = cyc;
        obs.nupd = nupd;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; nonzero = 4'b0000;
    #2;
    n_cmp++;
    if ({ld_init, ld_update, busy, done, winner_valid, winner_idx, timeout, iter_count} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000000000",
               {ld_init, ld_update, busy, done, winner_valid, winner_idx, timeout, iter_count});
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_winner;
    logic [3:0] s[4];
    res_t x;
    s = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
    drive_run(s, mk(1'b1, 2'd2, 1'b0, 4'd0, 3, 0), 0);
    x = exp_q.pop_front();
    n_cmp++; if (obs.res !== x.res) begin n_fail++; $display("FAIL single_result: got %b want %b", obs.res, x.res); end
    n_cmp++; if (obs.lat != x.lat) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", obs.lat, x.lat); end
    n_cmp++; if (obs.init_cyc != x.init_cyc) begin n_fail++; $display("FAIL single_ld_init_cycle: got %0d want %0d", obs.init_cyc, x.init_cyc); end
    n_cmp++; if (obs.nupd != x.nupd) begin n_fail++; $display("FAIL single_updates: got %0d want %0d", obs.nupd, x.nupd); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({winner_valid, winner_idx, done, busy} !== 5'b11000) begin
      n_fail++;
      $display("FAIL single_hold: got %b want 11000", {winner_valid, winner_idx, done, busy});
    end
  endtask

  task automatic test_two_updates;
    logic [3:0] s[4];
    res_t x;
    s = '{4'b1011, 4'b0011, 4'b1000, 4'b1000};
    drive_run(s, mk(1'b1, 2'd3, 1'b0, 4'd2, 7, 2), 0);
    x = exp_q.pop_front();
    n_cmp++; if (obs.res !== x.res) begin n_fail++; $display("FAIL two_upd_result: got %b want %b", obs.res, x.res); end
    n_cmp++; if (obs.lat != x.lat) begin n_fail++; $display("FAIL two_upd_latency: got %0d want %0d", obs.lat, x.lat); end
    n_cmp++; if (obs.nupd != x.nupd) begin n_fail++; $display("FAIL two_upd_updates: got %0d want %0d", obs.nupd, x.nupd); end
    n_cmp++; if (both_hi) begin n_fail++; $display("FAIL two_upd_strobe_overlap: got 1 want 0"); end
  endtask

  task automatic test_annihilate;
    logic [3:0] s[4];
    res_t x;
    s = '{4'b0110, 4'b0000, 4'b0000, 4'b0000};
    drive_run(s, mk(1'b0, 2'd0, 1'b0, 4'd1, 5, 1), 0);
    x = exp_q.pop_front();
    n_cmp++; if (obs.res !== x.res) begin n_fail++; $display("FAIL annihilate_result: got %b want %b", obs.res, x.res); end
    n_cmp++; if (obs.lat != x.lat) begin n_fail++; $display("FAIL annihilate_latency: got %0d want %0d", obs.lat, x.lat); end
    n_cmp++; if (obs.nupd != x.nupd) begin n_fail++; $display("FAIL annihilate_updates: got %0d want %0d", obs.nupd, x.nupd); end
  endtask

  task automatic test_timeout;
    logic [3:0] s[4];
    res_t x;
    s = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
`ifdef MAXNET_TIE_BREAK_EN
    drive_run(s, mk(1'b1, 2'd1, 1'b1, 4'd15, 33, 15), 0);
`else
    drive_run(s, mk(1'b0, 2'd0, 1'b1, 4'd15, 33, 15), 0);
`endif
    x = exp_q.pop_front();
    n_cmp++; if (obs.res !== x.res) begin n_fail++; $display("FAIL timeout_result: got %b want %b", obs.res, x.res); end
    n_cmp++; if (obs.lat != x.lat) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", obs.lat, x.lat); end
    n_cmp++; if (obs.nupd != x.nupd) begin n_fail++; $display("FAIL timeout_updates: got %0d want %0d", obs.nupd, x.nupd); end
    n_cmp++; if (both_hi) begin n_fail++; $display("FAIL timeout_strobe_overlap: got 1 want 0"); end
  endtask

  task automatic test_reset_mid_run;
    int  nupd;
    bit  hit;
    bit  bad;
    nupd = 0; hit = 0; bad = 0;
    nonzero = 4'b1011;
    start = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (ld_update) begin
        nupd++;
        if (nupd == 1) nonzero = 4'b0011;
        else hit = 1;
      end
    end
    n_cmp++;
    if (!hit || iter_count !== 4'd1) begin
      n_fail++;
      $display("FAIL midrun_pre_reset: got reached=%0b iter=%0d want reached=1 iter=1", hit, iter_count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ld_init, ld_update, busy, done, winner_valid, winner_idx, timeout, iter_count} !== 12'h000) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: got %b want 000000000000",
               {ld_init, ld_update, busy, done, winner_valid, winner_idx, timeout, iter_count});
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL midrun_idle_after: got done/busy activity want none"); end
  endtask

  task automatic test_start_ignored;
    logic [3:0] s[4];
    res_t x;
    s = '{4'b1011, 4'b0011, 4'b1000, 4'b1000};
    drive_run(s, mk(1'b1, 2'd3, 1'b0, 4'd2, 7, 2), 1);
    x = exp_q.pop_front();
    n_cmp++; if (obs.res !== x.res) begin n_fail++; $display("FAIL start_ignored_result: got %b want %b", obs.res, x.res); end
    n_cmp++; if (obs.lat != x.lat) begin n_fail++; $display("FAIL start_ignored_latency: got %0d want %0d", obs.lat, x.lat); end
    n_cmp++; if (obs.nupd != x.nupd) begin n_fail++; $display("FAIL start_ignored_updates: got %0d want %0d", obs.nupd, x.nupd); end
  endtask

  task automatic test_back_to_back;
    int got;
    int ndone;
    ndone = 0;
    nonzero = 4'b0100;
    exp_done_q.push_back(3);
    exp_done_q.push_back(7);
    exp_done_q.push_back(11);
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        n_cmp++;
        if ({ld_init, winner_valid} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_second_load: got ld_init,valid=%b want 10", {ld_init, winner_valid});
        end
      end
      if (done) begin
        ndone++;
        if (exp_done_q.size() == 0) got = -1;
        else got = exp_done_q.pop_front();
        n_cmp++;
        if (got != c) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want %0d", c, got); end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
    exp_done_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    nonzero = 4'b0000;
    test_reset();
    test_single_winner();
    test_two_updates();
    test_annihilate();
    test_timeout();
    test_reset_mid_run();
    test_single_winner();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
